decode_ibuf: RTL and testbench

//  Parametrised decode stage with an instruction buffer. Sits between fetch and execute.

---
 rtl/decode_ibuf_pkg.sv | 61 ++++++
 rtl/decode_ibuf_fifo.sv | 58 +++++
 rtl/decode_ibuf.sv | 153 +++++++++++++++
 tb/tb_decode_ibuf.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_ibuf_pkg.sv
`default_nettype none
// ============================================================================
// Module : decode_ibuf_pkg
// Brief  : Shared types, opcodes and immediate decode for the decode/ibuf stage.
// Rev    : 1.0
// ============================================================================
package decode_ibuf_pkg;

  // Entries hold the widest supported pc; narrower XLEN instances zero-extend.
  localparam int c_PC_MAX_W = 64;

  localparam logic [6:0] c_OP_LOAD   = 7'h03;
  localparam logic [6:0] c_OP_IMM    = 7'h13;
  localparam logic [6:0] c_OP_AUIPC  = 7'h17;
  localparam logic [6:0] c_OP_IMM32  = 7'h1b;
  localparam logic [6:0] c_OP_STORE  = 7'h23;
  localparam logic [6:0] c_OP_LUI    = 7'h37;
  localparam logic [6:0] c_OP_BRANCH = 7'h63;
  localparam logic [6:0] c_OP_JALR   = 7'h67;
  localparam logic [6:0] c_OP_JAL    = 7'h6f;
  localparam logic [6:0] c_OP_SYSTEM = 7'h73;

  typedef struct packed {
    logic [c_PC_MAX_W-1:0] pc;
    logic [31:0]           rawInstr;
  } ibuf_entry_t;

  typedef enum logic [1:0] {
    FWD_RD   = 2'd0,
    FWD_WB   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_RSVD = 2'd3
  } fwd_sel_t;

  typedef enum logic [0:0] {
    BR_IDLE = 1'b0,
    BR_CMP  = 1'b1
  } br_state_t;

  function automatic logic [63:0] immGen(input logic [31:0] instr);
    logic [63:0] imm;
    imm = '0;
    case (instr[6:0])
      c_OP_LOAD, c_OP_IMM, c_OP_IMM32, c_OP_JALR, c_OP_SYSTEM:
        imm = {{52{instr[31]}}, instr[31:20]};
      c_OP_STORE:
        imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      c_OP_BRANCH:
        imm = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      c_OP_LUI, c_OP_AUIPC:
        imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      c_OP_JAL:
        imm = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
    return imm;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_ibuf_fifo.sv
`default_nettype none
// ============================================================================
// Module : decode_ibuf_fifo
// Brief  : Circular instruction buffer with pointers, occupancy and clear.
// Rev    : 1.0
// ============================================================================
module decode_ibuf_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enq,
  input  logic deq,
  input  T     enqData,
  output T     headData,
  output logic empty,
  output logic full
);

  localparam int c_PTR_W = $clog2(DEPTH);

  T                   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_PTR_W:0]   r_count;
  logic               w_enq;
  logic               w_deq;

  assign empty    = (r_count == '0);
  assign full     = (r_count == (c_PTR_W + 1)'(DEPTH));
  assign w_deq    = deq && !empty;
  assign w_enq    = enq && (!full || w_deq);
  assign headData = r_mem[r_head];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + c_PTR_W'(1);
      if (w_deq) r_head <= r_head + c_PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq && !clear) r_mem[r_tail] <= enqData;
  end

endmodule
`default_nettype wire

// File: rtl/decode_ibuf.sv
`default_nettype none
// ============================================================================
// Module : decode_ibuf
// Brief  : Decode stage with instruction buffer, operand forwarding and redirect.
// Rev    : 1.0
// ============================================================================
module decode_ibuf
  import decode_ibuf_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int DEPTH  = 4,
  parameter int BR_REG = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic [4:0]      ra1,
  output logic [4:0]      ra2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] aluout_m,
  input  logic [XLEN-1:0] result_w,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic            stall_d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_srca,
  output logic [XLEN-1:0] out_srcb,
  output logic [XLEN-1:0] out_imm,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  ibuf_entry_t     w_enqEntry, w_head;
  logic            w_empty, w_full, w_enqFire, w_deqFire, w_redirFire, w_clear;
  logic            w_outValid, w_selTaken, w_isBranch, w_isJal, w_isJalr, w_isCtl;
  logic            w_cond, w_takenNow;
  logic [63:0]     w_imm64;
  logic [XLEN-1:0] w_pc, w_imm, w_srcA, w_srcB, w_targetNow, w_selTarget;
  logic [31:0]     w_instr;

  function automatic logic [XLEN-1:0] fwdMux(input logic [1:0] sel, input logic [XLEN-1:0] rd,
                                             input logic [XLEN-1:0] wb, input logic [XLEN-1:0] mem);
    case (fwd_sel_t'(sel))
      FWD_WB:  return wb;
      FWD_MEM: return mem;
      default: return rd;
    endcase
  endfunction

  assign w_enqEntry = '{pc: c_PC_MAX_W'(in_pc), rawInstr: in_instr};
  assign w_enqFire  = in_valid && !w_full;
  assign in_ready   = !w_full;

  decode_ibuf_fifo #(
    .DEPTH (DEPTH),
    .T     (ibuf_entry_t)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_clear),
    .enq      (w_enqFire),
    .deq      (w_deqFire),
    .enqData  (w_enqEntry),
    .headData (w_head),
    .empty    (w_empty),
    .full     (w_full)
  );

  assign w_instr    = w_head.rawInstr;
  assign w_pc       = w_head.pc[XLEN-1:0];
  assign w_imm64    = immGen(w_instr);
  assign w_imm      = w_imm64[XLEN-1:0];
  assign w_srcA     = fwdMux(fwd_a, rd1, result_w, aluout_m);
  assign w_srcB     = fwdMux(fwd_b, rd2, result_w, aluout_m);
  assign w_isBranch = (w_instr[6:0] == c_OP_BRANCH);
  assign w_isJal    = (w_instr[6:0] == c_OP_JAL);
  assign w_isJalr   = (w_instr[6:0] == c_OP_JALR);
  assign w_isCtl    = w_isBranch || w_isJal || w_isJalr;

  always_comb begin
    case (w_instr[14:12])
      3'b000:  w_cond = (w_srcA == w_srcB);
      3'b001:  w_cond = (w_srcA != w_srcB);
      3'b100:  w_cond = ($signed(w_srcA) <  $signed(w_srcB));
      3'b101:  w_cond = ($signed(w_srcA) >= $signed(w_srcB));
      3'b110:  w_cond = (w_srcA <  w_srcB);
      3'b111:  w_cond = (w_srcA >= w_srcB);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_takenNow  = (w_isBranch && w_cond) || w_isJal || w_isJalr;
  assign w_targetNow = w_isJalr ? ((w_srcA + w_imm) & ~XLEN'(1)) : (w_pc + w_imm);

  generate
    if (BR_REG != 0) begin : g_brReg
      br_state_t       r_state;
      logic            r_taken;
      logic [XLEN-1:0] r_target;

      // The compare result is captured once on entry to CMP and held across stalls.
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          r_state  <= BR_IDLE;
          r_taken  <= 1'b0;
          r_target <= '0;
        end else begin
          case (r_state)
            BR_IDLE: if (!w_empty && w_isCtl) begin
              r_state  <= BR_CMP;
              r_taken  <= w_takenNow;
              r_target <= w_targetNow;
            end
            BR_CMP: if (w_deqFire) r_state <= BR_IDLE;
          endcase
        end
      end

      assign w_outValid  = !w_empty && (!w_isCtl || (r_state == BR_CMP));
      assign w_selTaken  = (r_state == BR_CMP) && r_taken;
      assign w_selTarget = r_target;
    end else begin : g_brComb
      assign w_outValid  = !w_empty;
      assign w_selTaken  = w_takenNow;
      assign w_selTarget = w_targetNow;
    end
  endgenerate

  assign w_deqFire   = w_outValid && out_ready && !stall_d;
  assign w_redirFire = w_deqFire && w_selTaken;
  assign w_clear     = flush || w_redirFire;

  assign out_valid      = w_outValid;
  assign out_pc         = w_pc;
  assign out_instr      = w_instr;
  assign out_srca       = w_srcA;
  assign out_srcb       = w_srcB;
  assign out_imm        = w_imm;
  assign ra1            = w_instr[19:15];
  assign ra2            = w_instr[24:20];
  assign redirect_valid = w_redirFire && !flush;
  assign redirect_pc    = w_selTarget;

endmodule
`default_nettype wire

// File: tb/tb_decode_ibuf.sv
`default_nettype none
// ============================================================================
// Module : tb_decode_ibuf
// Brief  : Directed and randomized checks of decode_ibuf against a queue model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_decode_ibuf;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, stall_d, out_ready;
  logic [63:0] in_pc, rd1, rd2, aluout_m, result_w;
  logic [31:0] in_instr;
  logic [1:0]  fwd_a, fwd_b;

  logic        d0_in_ready, d0_out_valid, d0_redirect_valid;
  logic [4:0]  d0_ra1, d0_ra2;
  logic [63:0] d0_out_pc, d0_out_srca, d0_out_srcb, d0_out_imm, d0_redirect_pc;
  logic [31:0] d0_out_instr;
  logic        d1_in_ready, d1_out_valid, d1_redirect_valid;
  logic [4:0]  d1_ra1, d1_ra2;
  logic [63:0] d1_out_pc, d1_out_srca, d1_out_srcb, d1_out_imm, d1_redirect_pc;
  logic [31:0] d1_out_instr;

  decode_ibuf #(.XLEN(XLEN), .DEPTH(DEPTH), .BR_REG(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d0_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .ra1(d0_ra1), .ra2(d0_ra2), .rd1(rd1), .rd2(rd2),
    .aluout_m(aluout_m), .result_w(result_w), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_d(stall_d),
    .out_valid(d0_out_valid), .out_ready(out_ready), .out_pc(d0_out_pc), .out_instr(d0_out_instr),
    .out_srca(d0_out_srca), .out_srcb(d0_out_srcb), .out_imm(d0_out_imm),
    .redirect_valid(d0_redirect_valid), .redirect_pc(d0_redirect_pc));

  decode_ibuf #(.XLEN(XLEN), .DEPTH(DEPTH), .BR_REG(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d1_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .ra1(d1_ra1), .ra2(d1_ra2), .rd1(rd1), .rd2(rd2),
    .aluout_m(aluout_m), .result_w(result_w), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_d(stall_d),
    .out_valid(d1_out_valid), .out_ready(out_ready), .out_pc(d1_out_pc), .out_instr(d1_out_instr),
    .out_srca(d1_out_srca), .out_srcb(d1_out_srcb), .out_imm(d1_out_imm),
    .redirect_valid(d1_redirect_valid), .redirect_pc(d1_redirect_pc));

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mDeq, mTk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction encoders: the bench builds instructions from field values.
  function automatic logic [31:0] encI(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] encB(input logic [2:0] f3, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [12:0] m);
    return {m[12], m[10:5], rs2, rs1, f3, m[4:1], m[11], 7'h63};
  endfunction

  function automatic logic [31:0] encJ(input logic [4:0] rd, input logic [20:0] m);
    return {m[20], m[10:1], m[11], m[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [63:0] refImm(input logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h13, 7'h1b, 7'h67, 7'h73: return {{52{i[31]}}, i[31:20]};
      7'h23: return {{52{i[31]}}, i[31:25], i[11:7]};
      7'h63: return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17: return {{32{i[31]}}, i[31:12], 12'b0};
      7'h6f: return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] refSel(input logic [1:0] sel, input logic [63:0] rd);
    if (sel == 2'd1) return result_w;
    if (sel == 2'd2) return aluout_m;
    return rd;
  endfunction

  function automatic bit refTaken(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
    if (i[6:0] == 7'h6f || i[6:0] == 7'h67) return 1'b1;
    if (i[6:0] != 7'h63) return 1'b0;
    case (i[14:12])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] refTarget(input ent_t e, input logic [63:0] a);
    if (e.ins[6:0] == 7'h67) return (a + refImm(e.ins)) & ~64'h1;
    return e.pc + refImm(e.ins);
  endfunction

  function automatic logic [31:0] randInstr();
    int         k;
    logic [4:0] r1, r2, rdd;
    k   = $urandom_range(10);
    r1  = 5'($urandom_range(31));
    r2  = 5'($urandom_range(31));
    rdd = 5'($urandom_range(31));
    case (k)
      0, 1, 2, 3: return encI(7'h13, 3'($urandom_range(7)), rdd, r1, 12'($urandom));
      4:          return {7'($urandom), r2, r1, 3'b011, 5'($urandom), 7'h23};
      5, 6, 7:    return encB(3'($urandom_range(7)), r1, r2, 13'($urandom) & ~13'h1);
      8:          return encJ(rdd, 21'($urandom) & ~21'h1);
      9:          return encI(7'h67, 3'b000, rdd, r1, 12'($urandom));
      default:    return {20'($urandom), rdd, 7'h37};
    endcase
  endfunction

  // Compare the BR_REG=0 instance against the queue model for this cycle.
  task automatic settle();
    logic [63:0] a, b;
    bit          expRedir;
    #1;
    mDeq = 1'b0; mTk = 1'b0; expRedir = 1'b0;
    chk("in_ready", d0_in_ready, q.size() < DEPTH);
    chk("out_valid", d0_out_valid, q.size() != 0);
    if (q.size() != 0) begin
      a = refSel(fwd_a, rd1);
      b = refSel(fwd_b, rd2);
      chk("out_pc", d0_out_pc, q[0].pc);
      chk("out_instr", d0_out_instr, q[0].ins);
      chk("out_imm", d0_out_imm, refImm(q[0].ins));
      chk("out_srca", d0_out_srca, a);
      chk("out_srcb", d0_out_srcb, b);
      chk("ra1", d0_ra1, q[0].ins[19:15]);
      chk("ra2", d0_ra2, q[0].ins[24:20]);
      mDeq = out_ready && !stall_d;
      mTk  = mDeq && refTaken(q[0].ins, a, b);
      expRedir = mTk && !flush;
      if (expRedir) chk("redirect_pc", d0_redirect_pc, refTarget(q[0], a));
    end
    chk("redirect_valid", d0_redirect_valid, expRedir);
  endtask

  task automatic tick();
    bit   enq;
    ent_t e;
    enq = in_valid && (q.size() < DEPTH);
    if (reset || flush || mTk) q.delete();
    else begin
      if (mDeq) void'(q.pop_front());
      if (enq) begin
        e.pc = in_pc; e.ins = in_instr;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    reset = 0; flush = 0; in_valid = 0; stall_d = 0; out_ready = 0;
    fwd_a = 0; fwd_b = 0;
  endtask

  logic [63:0] expOut, nextIn;
  bit          e;

  initial begin
    quiet();
    in_pc = 0; in_instr = 0; rd1 = 0; rd2 = 0; aluout_m = 0; result_w = 0;
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;

    // Reset state on both instances
    settle();
    chk("rst_in_ready_br1", d1_in_ready, 1);
    chk("rst_out_valid_br1", d1_out_valid, 0);
    chk("rst_redirect_br1", d1_redirect_valid, 0);
    tick();

    // Fill: five offers with execute blocked, the fifth is held
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_pc = 64'(i * 4); in_instr = encI(7'h13, 3'd0, 5'd1, 5'd0, 12'(i));
      settle();
      if (i == 4) chk("fill_held", d0_in_ready, 0);
      tick();
    end

    // Streaming with the buffer near full: program order preserved
    expOut = 0; nextIn = 64'h10;
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      e = (q.size() < DEPTH);
      settle();
      chk("order", d0_out_pc, expOut);
      expOut += 4;
      tick();
      if (e) begin
        nextIn += 4; in_pc = nextIn; in_instr = encI(7'h13, 3'd0, 5'd2, 5'd0, 12'(nextIn));
      end
    end
    in_valid = 0;
    for (int i = 0; i < 6; i++) begin settle(); tick(); end

    // beq taken: redirect to 0x120, younger enqueue dropped
    quiet(); rd1 = 5; rd2 = 5;
    in_valid = 1; in_pc = 64'h100; in_instr = encB(3'd0, 5'd1, 5'd2, 13'h20);
    settle(); tick();
    in_pc = 64'h104; in_instr = encI(7'h13, 3'd0, 5'd3, 5'd0, 12'h7); out_ready = 1;
    settle();
    chk("beq_redir_v", d0_redirect_valid, 1);
    chk("beq_redir_pc", d0_redirect_pc, 64'h120);
    tick();
    in_valid = 0;
    settle();
    chk("beq_empty", d0_out_valid, 0);
    tick();

    // jalr via MEM forward then via WB forward
    quiet(); aluout_m = 64'h2001; result_w = 64'h3005;
    in_valid = 1; in_pc = 64'h400; in_instr = encI(7'h67, 3'd0, 5'd1, 5'd5, 12'h0);
    settle(); tick();
    in_valid = 0; out_ready = 1; fwd_a = 2;
    settle();
    chk("jalr_mem_pc", d0_redirect_pc, 64'h2000);
    tick();
    quiet();
    in_valid = 1; in_pc = 64'h410; in_instr = encI(7'h67, 3'd0, 5'd1, 5'd5, 12'h0);
    settle(); tick();
    in_valid = 0; out_ready = 1; fwd_a = 1;
    settle();
    chk("jalr_wb_pc", d0_redirect_pc, 64'h3004);
    tick();

    // flush coinciding with a taken branch
    quiet(); rd1 = 5; rd2 = 5;
    in_valid = 1; in_pc = 64'h500; in_instr = encB(3'd0, 5'd1, 5'd2, 13'h20);
    settle(); tick();
    in_pc = 64'h504; in_instr = encI(7'h13, 3'd0, 5'd3, 5'd0, 12'h1); out_ready = 1; flush = 1;
    settle();
    chk("flush_no_redir", d0_redirect_valid, 0);
    tick();
    quiet();
    settle();
    chk("flush_empty", d0_out_valid, 0);
    tick();

    // reset with three queued entries
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_pc = 64'h600 + 64'(i * 4); in_instr = encI(7'h13, 3'd0, 5'd4, 5'd0, 12'(i));
      settle(); tick();
    end
    in_valid = 0; reset = 1;
    settle(); tick();
    reset = 0;
    settle();
    chk("rst3_ready", d0_in_ready, 1);
    chk("rst3_empty", d0_out_valid, 0);
    tick();

    // BR_REG=1: bne not taken costs one bubble, no redirect
    quiet(); rd1 = 5; rd2 = 5; out_ready = 1;
    in_valid = 1; in_pc = 64'h200; in_instr = encB(3'd1, 5'd1, 5'd2, 13'h10);
    settle(); tick();
    in_pc = 64'h204; in_instr = encI(7'h13, 3'd0, 5'd3, 5'd0, 12'h9);
    settle();
    chk("br1_bubble", d1_out_valid, 0);
    tick();
    in_valid = 0;
    settle();
    chk("br1_valid", d1_out_valid, 1);
    chk("br1_pc", d1_out_pc, 64'h200);
    chk("br1_noredir", d1_redirect_valid, 0);
    tick();
    settle();
    chk("br1_next_v", d1_out_valid, 1);
    chk("br1_next_pc", d1_out_pc, 64'h204);
    tick();
    settle();
    chk("br1_drained", d1_out_valid, 0);
    tick();

    // BR_REG=1: taken bne, operands change during stall, latched result used
    quiet(); rd1 = 5; rd2 = 6; out_ready = 1; stall_d = 1;
    in_valid = 1; in_pc = 64'h300; in_instr = encB(3'd1, 5'd1, 5'd2, 13'h40);
    settle(); tick();
    in_valid = 0;
    settle();
    chk("br1t_bubble", d1_out_valid, 0);
    tick();
    rd2 = 5;
    settle();
    chk("br1t_stall_v", d1_out_valid, 1);
    chk("br1t_stall_noredir", d1_redirect_valid, 0);
    tick();
    stall_d = 0;
    settle();
    chk("br1t_redir_v", d1_redirect_valid, 1);
    chk("br1t_redir_pc", d1_redirect_pc, 64'h340);
    tick();
    settle();
    chk("br1t_empty", d1_out_valid, 0);
    tick();

    // Randomized traffic on the BR_REG=0 instance
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(99) == 0);
      flush     = ($urandom_range(24) == 0);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      stall_d   = ($urandom_range(5) == 0);
      fwd_a     = 2'($urandom_range(3));
      fwd_b     = 2'($urandom_range(3));
      rd1       = {$urandom, $urandom};
      rd2       = ($urandom_range(2) == 0) ? rd1 : {$urandom, $urandom};
      aluout_m  = {$urandom, $urandom};
      result_w  = {$urandom, $urandom};
      in_pc     = {$urandom, $urandom};
      in_instr  = randInstr();
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
